// File: rtl/pbvi_pkg.sv
// pbvi_pkg: shared sizes, types and helpers for the PBVI pipeline stages
package pbvi_pkg;
    localparam int N_BELIEF = 16;
    localparam int N_ACTION = 3;
    localparam int N_STATE  = 2;
    localparam int W        = 16;
    localparam int IW       = $clog2(N_BELIEF);
    typedef logic [1:0] act_t;
    typedef logic [2*W:0] dot_t;
    typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} state_t;
    function automatic logic [W-1:0] absdiff(input logic [W-1:0] x, input logic [W-1:0] y);
        return x > y ? x - y : y - x;
    endfunction
endpackage

// File: rtl/step3_if.sv
// step3_if: step3 start/data/result bundle; delta ports exist only with STEP3_DELTA_EN
interface step3_if;
    import pbvi_pkg::*;
    logic         en;
    logic [W-1:0] gamma_action_bilief [0:N_ACTION-1][0:N_BELIEF-1][0:N_STATE-1];
    logic [W-1:0] point_belief [0:N_BELIEF-1][0:N_STATE-1];
    logic         busy;
    logic         en_step4;
    logic [W-1:0] alpha_new [0:N_BELIEF-1][0:N_STATE-1];
    act_t         best_action [0:N_BELIEF-1];
`ifdef STEP3_DELTA_EN
    logic [W-1:0] conv_thresh;
    logic [W-1:0] delta;
    logic         converged;
    modport master (output en, gamma_action_bilief, point_belief, conv_thresh,
                    input busy, en_step4, alpha_new, best_action, delta, converged);
    modport slave  (input en, gamma_action_bilief, point_belief, conv_thresh,
                    output busy, en_step4, alpha_new, best_action, delta, converged);
`else
    modport master (output en, gamma_action_bilief, point_belief,
                    input busy, en_step4, alpha_new, best_action);
    modport slave  (input en, gamma_action_bilief, point_belief,
                    output busy, en_step4, alpha_new, best_action);
`endif
endinterface

// File: rtl/step3_argmax.sv
// step3_argmax: combinational N_ACTION-way maximum, ties go to the lowest action index
module step3_argmax
    import pbvi_pkg::*;
(
    input  dot_t dot [0:N_ACTION-1],
    output act_t best,
    output dot_t best_val
);
    // strict greater-than keeps the earliest index on equal dot products
    always_comb begin
        best     = '0;
        best_val = dot[0];
        for (int a = 1; a < N_ACTION; a++) begin
            best     = dot[a] > best_val ? act_t'(a) : best;
            best_val = dot[a] > best_val ? dot[a] : best_val;
        end
    end
endmodule

// File: rtl/step3.sv
// step3: PBVI backup selection (dot products, argmax, alpha write); macro STEP3_DELTA_EN adds delta/convergence outputs
module step3
    import pbvi_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    step3_if.slave bus
);
    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_d;
    logic          v1;
    logic          en_step4_q;
    logic [W-1:0]  g_s [0:N_ACTION-1][0:N_BELIEF-1][0:N_STATE-1];
    logic [W-1:0]  b_s [0:N_BELIEF-1][0:N_STATE-1];
    logic [W-1:0]  alpha_q [0:N_BELIEF-1][0:N_STATE-1];
    act_t          best_q [0:N_BELIEF-1];
    dot_t          dot_c [0:N_ACTION-1];
    dot_t          dot_q [0:N_ACTION-1];
    act_t          best;

    // full-precision dot product of every candidate with the current snapshot belief
    always_comb begin
        for (int a = 0; a < N_ACTION; a++) begin
            dot_c[a] = '0;
            for (int s = 0; s < N_STATE; s++)
                dot_c[a] = dot_c[a] + dot_t'(g_s[a][idx][s]) * dot_t'(b_s[idx][s]);
        end
    end

    step3_argmax u_argmax (.dot(dot_q), .best(best), .best_val());

`ifdef STEP3_DELTA_EN
    logic [W-1:0] cur_diff;
    logic [W-1:0] max_next;
    logic [W-1:0] run_max;
    logic [W-1:0] delta_q;
    logic         conv_q;

    // largest element change of the in-flight write folded into the run maximum
    always_comb begin
        cur_diff = '0;
        for (int s = 0; s < N_STATE; s++)
            cur_diff = absdiff(g_s[best][idx_d][s], alpha_q[idx_d][s]) > cur_diff ?
                       absdiff(g_s[best][idx_d][s], alpha_q[idx_d][s]) : cur_diff;
        max_next = v1 && cur_diff > run_max ? cur_diff : run_max;
    end

    assign bus.delta     = delta_q;
    assign bus.converged = conv_q;
`endif

    // FSM, snapshot, two-stage pipeline and result registers; en restarts from any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            idx_d      <= '0;
            v1         <= 1'b0;
            en_step4_q <= 1'b0;
            g_s        <= '{default: '0};
            b_s        <= '{default: '0};
            dot_q      <= '{default: '0};
            alpha_q    <= '{default: '0};
            best_q     <= '{default: '0};
`ifdef STEP3_DELTA_EN
            run_max    <= '0;
            delta_q    <= '0;
            conv_q     <= 1'b0;
`endif
        end else if (bus.en) begin
            state      <= CALC;
            idx        <= '0;
            v1         <= 1'b0;
            en_step4_q <= 1'b0;
            g_s        <= bus.gamma_action_bilief;
            b_s        <= bus.point_belief;
`ifdef STEP3_DELTA_EN
            run_max    <= '0;
`endif
        end else begin
            if (v1) begin
                alpha_q[idx_d] <= g_s[best][idx_d];
                best_q[idx_d]  <= best;
            end
            if (state == CALC) begin
                dot_q <= dot_c;
                idx_d <= idx;
                idx   <= idx + 1'b1;
            end
            v1         <= state == CALC;
            en_step4_q <= state == DRAIN;
            state      <= state == CALC  ? (idx == IW'(N_BELIEF - 1) ? DRAIN : CALC) :
                          state == DRAIN ? DONE : IDLE;
`ifdef STEP3_DELTA_EN
            run_max <= max_next;
            if (state == DRAIN) begin
                delta_q <= max_next;
                conv_q  <= max_next < bus.conv_thresh;
            end
`endif
        end
    end

    assign bus.busy        = state != IDLE;
    assign bus.en_step4    = en_step4_q;
    assign bus.alpha_new   = alpha_q;
    assign bus.best_action = best_q;
endmodule
